// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers (MIPS E stage).
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 7-10).
module mdu_hilo #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [63:0]       shadow_q, shadow_d;
  logic              wr_q, wr_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, q_m, r_m, q_s, r_s, q_u, r_u;
  logic        accept;

  // Sign-extend to 64 bits so the low 64 bits of the product are the signed result.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
  assign mag_a = a[31] ? (32'd0 - a) : a;
  assign mag_b = b[31] ? (32'd0 - b) : b;
  assign q_m   = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
  assign r_m   = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
  assign q_s   = (a[31] ^ b[31]) ? (32'd0 - q_m) : q_m;
  assign r_s   = a[31] ? (32'd0 - r_m) : r_m;
  assign q_u   = (b == 32'd0) ? 32'd0 : a / b;
  assign r_u   = (b == 32'd0) ? 32'd0 : a % b;

  assign accept = start && !cancel && (state_q == StIdle);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    wr_d     = wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpMthi: hi_d = a;
            OpMtlo: lo_d = a;
            OpMult, OpMultu: begin
              shadow_d = (op == OpMult) ? prod_s : prod_u;
              wr_d     = 1'b1;
              cnt_d    = CntW'(MULT_CYCLES);
              state_d  = StRun;
            end
            OpDiv, OpDivu: begin
              shadow_d = (op == OpDiv) ? {r_s, q_s} : {r_u, q_u};
              // Divide by zero still occupies the unit but leaves HI/LO untouched.
              wr_d     = (b != 32'd0);
              cnt_d    = CntW'(DIV_CYCLES);
              state_d  = StRun;
            end
`ifdef MDU_MADD_EN
            OpMadd, OpMaddu, OpMsub, OpMsubu: begin
              // HI/LO cannot change while busy, so accumulating at accept is equivalent.
              if (op == OpMadd)       shadow_d = {hi_q, lo_q} + prod_s;
              else if (op == OpMaddu) shadow_d = {hi_q, lo_q} + prod_u;
              else if (op == OpMsub)  shadow_d = {hi_q, lo_q} - prod_s;
              else                    shadow_d = {hi_q, lo_q} - prod_u;
              wr_d    = 1'b1;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
`endif
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (wr_q) begin
            hi_d = shadow_q[63:32];
            lo_d = shadow_q[31:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      wr_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      wr_q     <= wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo; accumulate ops are exercised when MDU_MADD_EN is set.
module tb_mdu_hilo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_hilo #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .cancel(cancel),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one op for a single edge; returns #1 after that edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic c);
    start = 1'b1; op = o; a = x; b = y; cancel = c;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0; a = '0; b = '0; cancel = 1'b0;
  endtask

  // Counts sampled cycles with busy high, bounded so a stuck unit cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 4'd0; cancel = 1'b0; a = '0; b = '0;
    #3;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_mthi();
    issue(4'd5, 32'h1234_5678, 32'd0, 1'b1);
    n_checks++;
    if (hi !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_cancel: hi=%h busy=%b, want 00000000/0", hi, busy);
    end
    issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    n_checks++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b, want 12345678/00000000/0", hi, lo, busy);
    end
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    n_checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL mult_hold: hi=%h lo=%h, want 12345678/00000000", hi, lo);
    end
    count_busy(n);
    n_checks++;
    if (n != 5) begin
      n_fail++;
      $display("FAIL mult_latency: busy cycles=%0d, want 5", n);
    end
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL mult_result: hi=%h lo=%h, want ffffffff/fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    // Cancel during a run must not abort it.
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    count_busy(n);
    n_checks++;
    if (n != 9) begin
      n_fail++;
      $display("FAIL div_latency: busy cycles after first=%0d, want 9", n);
    end
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_result: hi=%h lo=%h, want ffffffff/fffffffd", hi, lo);
    end
    issue(4'd4, 32'd7, 32'd0, 1'b0);
    count_busy(n);
    n_checks++;
    if (n != 10 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL divu_zero: cycles=%0d hi=%h lo=%h, want 10/ffffffff/fffffffd", n, hi, lo);
    end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL div_overflow: hi=%h lo=%h, want 00000000/80000000", hi, lo);
    end
    issue(4'd4, 32'd100, 32'd7, 1'b0);
    count_busy(n);
    n_checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      n_fail++;
      $display("FAIL divu_result: hi=%h lo=%h, want 00000002/0000000e", hi, lo);
    end
    issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
    count_busy(n);
    n_checks++;
    if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_negdivisor: hi=%h lo=%h, want 00000001/fffffffd", hi, lo);
    end
  endtask

  task automatic test_multu_reset();
    int n;
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(4'd6, 32'h0000_AAAA, 32'd0, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      n_fail++;
      $display("FAIL busy_ignore: busy=%b hi=%h lo=%h, want 1/00000001/fffffffd", busy, hi, lo);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_discard: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    end
    // Full MULTU still works after reset.
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
    n_checks++;
    if (n != 5 || hi !== 32'hFFFF_FFFE || lo !== 32'd1) begin
      n_fail++;
      $display("FAIL multu_result: cycles=%0d hi=%h lo=%h, want 5/fffffffe/00000001", n, hi, lo);
    end
  endtask

  task automatic test_madd();
    int n;
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'd10, 32'd0, 1'b0);
    issue(4'd7, 32'd2, 32'd3, 1'b0);
`ifdef MDU_MADD_EN
    count_busy(n);
    n_checks++;
    if (n != 5 || hi !== 32'd0 || lo !== 32'd16) begin
      n_fail++;
      $display("FAIL madd: cycles=%0d hi=%h lo=%h, want 5/00000000/00000010", n, hi, lo);
    end
    issue(4'd10, 32'd5, 32'd4, 1'b0);
    count_busy(n);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL msubu: hi=%h lo=%h, want ffffffff/fffffffc", hi, lo);
    end
`else
    n = busy ? 1 : 0;
    n_checks++;
    if (n != 0 || lo !== 32'd10 || hi !== 32'd0) begin
      n_fail++;
      $display("FAIL op7_disabled: busy=%0d hi=%h lo=%h, want 0/00000000/0000000a", n, hi, lo);
    end
`endif
    issue(4'd11, 32'd9, 32'd9, 1'b0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_op: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_mthi();
    test_mult();
    test_div();
    test_multu_reset();
    test_madd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
